// File: rtl/cla_pkg.sv
// Shared types and configuration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int num_blk(input int width, input int blk_w);
        return width / blk_w;
    endfunction

    function automatic bit cfg_ok(input int width, input int blk_w);
        return (blk_w > 0) && (width >= blk_w) && ((width % blk_w) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK_W-bit carry-lookahead block.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] a_i,
    input  logic [BLK_W-1:0] b_i,
    input  logic             cin_i,
    output logic [BLK_W-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    gp_t  [BLK_W-1:0] gp;
    logic [BLK_W:0]   c;
    logic             prod;

    always_comb begin
        for (int i = 0; i < BLK_W; i++) begin
            gp[i].g = a_i[i] & b_i[i];
            gp[i].p = a_i[i] | b_i[i];
        end
    end

    // Each carry is a flat sum-of-products over the block, no rippling.
    always_comb begin
        c    = '0;
        prod = 1'b0;
        c[0] = cin_i;
        for (int i = 0; i < BLK_W; i++) begin
            c[i+1] = gp[i].g;
            prod   = gp[i].p;
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (gp[j].g & prod);
                prod   = prod & gp[j].p;
            end
            c[i+1] = c[i+1] | (prod & cin_i);
        end
    end

    assign sum_o  = a_i ^ b_i ^ c[BLK_W-1:0];
    assign cout_o = c[BLK_W];
    assign cmsb_o = c[BLK_W-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one lookahead block per stage,
// with a global valid/ready stall.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLK_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int NUM_BLK = num_blk(WIDTH, BLK_W);

    if (!cfg_ok(WIDTH, BLK_W)) begin : g_cfg_err
        $error("cla_pipe_addsub: WIDTH must be a multiple of BLK_W");
    end

    logic                            advance;
    logic [NUM_BLK-1:0]              v_q, v_d;
    logic [NUM_BLK-1:0]              c_q, c_d;
    logic [NUM_BLK-1:0][WIDTH-1:0]   a_q, a_d;
    logic [NUM_BLK-1:0][WIDTH-1:0]   b_q, b_d;
    logic [NUM_BLK-1:0][WIDTH-1:0]   s_q, s_d;
    logic                            ovf_q, ovf_d;
    logic                            unused_ops;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_stg
        logic [WIDTH-1:0] a_in, b_in, s_in, s_blk;
        logic             c_in, v_in;
        logic [BLK_W-1:0] sum;
        logic             cout, cmsb;

        if (k == 0) begin : g_head
            assign a_in = i_add1;
            assign b_in = i_sub ? ~i_add2 : i_add2;
            assign c_in = i_sub | i_carry;
            assign s_in = '0;
            assign v_in = i_valid;
        end else begin : g_body
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign c_in = c_q[k-1];
            assign s_in = s_q[k-1];
            assign v_in = v_q[k-1];
        end

        cla_block #(.BLK_W(BLK_W)) u_blk (
            .a_i    (a_in[k*BLK_W +: BLK_W]),
            .b_i    (b_in[k*BLK_W +: BLK_W]),
            .cin_i  (c_in),
            .sum_o  (sum),
            .cout_o (cout),
            .cmsb_o (cmsb)
        );

        always_comb begin
            s_blk                    = s_in;
            s_blk[k*BLK_W +: BLK_W]  = sum;
        end

        assign a_d[k] = a_in;
        assign b_d[k] = b_in;
        assign s_d[k] = s_blk;
        assign c_d[k] = cout;
        assign v_d[k] = v_in;

        if (k == NUM_BLK - 1) begin : g_tail
            assign ovf_d = cmsb ^ cout;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    // Operand bits of already-resolved blocks are simply dropped downstream.
    assign unused_ops = ^{a_q, b_q};

    assign o_valid    = v_q[NUM_BLK-1];
    assign o_result   = s_q[NUM_BLK-1];
    assign o_carry    = c_q[NUM_BLK-1];
    assign o_overflow = ovf_q;

endmodule
